// File: rtl/sa9_grant_scheduler_if.sv
// Leaf-side handshake bundle for sa9_grant_scheduler: request/done in, grant and watchdog status out.
// The master side is the set of leaves and the slave side is the scheduler.
interface sa9_grant_scheduler_if #(
   parameter int NUM_REQ = 5,
   parameter int ID_W    = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] done;
   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_id;
   logic               busy;
   logic               timeout_pulse;
   logic [ID_W-1:0]    timeout_id;

   modport master (
      output req, done,
      input  grant, grant_id, busy, timeout_pulse, timeout_id
   );

   modport slave (
      input  req, done,
      output grant, grant_id, busy, timeout_pulse, timeout_id
   );
endinterface

// File: rtl/sa9_grant_scheduler.sv
// Round-robin one-hot grant scheduler for NUM_REQ leaves sharing one resource.
// Define SA9_SCHED_WATCHDOG_EN to build the hung-grant watchdog (timeout_pulse/timeout_id).
module sa9_grant_scheduler #(
   parameter int NUM_REQ     = 5,
   parameter int ID_W        = $clog2(NUM_REQ),
   parameter int TIMEOUT_CYC = 200,
   parameter int TMR_W       = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sa9_grant_scheduler_if.slave sched_if
);

   localparam bit CFG_OK = (NUM_REQ >= 2) && (NUM_REQ <= 16) &&
                           (TIMEOUT_CYC >= 2) && ((64'd1 << TMR_W) > 64'(TIMEOUT_CYC));

   if (!CFG_OK) begin : g_cfg_err
      $error("sa9_grant_scheduler: illegal NUM_REQ/TIMEOUT_CYC/TMR_W combination");
   end

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t             state_q;
   logic [ID_W-1:0]    ptr_q;
   logic [NUM_REQ-1:0] grant_q;
   logic [ID_W-1:0]    gid_q;
   logic               busy_q;

   logic [ID_W-1:0]    pick_id;
   logic               pick_vld;
   logic [NUM_REQ-1:0] pick_oh;
   logic [ID_W-1:0]    ptr_d;
   logic               done_hit;

   // Scan downward so the lowest offset from ptr_q wins without needing a break.
   always_comb begin
      int idx;
      pick_vld = 1'b0;
      pick_id  = '0;
      idx      = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (sched_if.req[idx]) begin
            pick_vld = 1'b1;
            pick_id  = ID_W'(idx);
         end
      end
   end

   assign pick_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_id;
   assign ptr_d    = (gid_q == ID_W'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
   assign done_hit = sched_if.done[gid_q];

`ifdef SA9_SCHED_WATCHDOG_EN
   logic [TMR_W-1:0]   tmr_q;
   logic               tpulse_q;
   logic [ID_W-1:0]    tid_q;
   logic               expire;

   assign expire = (tmr_q == TMR_W'(TIMEOUT_CYC - 1));
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         grant_q  <= '0;
         gid_q    <= '0;
         busy_q   <= 1'b0;
`ifdef SA9_SCHED_WATCHDOG_EN
         tmr_q    <= '0;
         tpulse_q <= 1'b0;
         tid_q    <= '0;
`endif
      end else begin
`ifdef SA9_SCHED_WATCHDOG_EN
         tpulse_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (pick_vld) begin
                  state_q <= GRANT;
                  grant_q <= pick_oh;
                  gid_q   <= pick_id;
                  busy_q  <= 1'b1;
`ifdef SA9_SCHED_WATCHDOG_EN
                  tmr_q   <= '0;
`endif
               end
            end
            GRANT: begin
               // done wins over a coincident expiry, so no timeout is reported then.
               if (done_hit) begin
                  state_q <= IDLE;
                  grant_q <= '0;
                  busy_q  <= 1'b0;
                  ptr_q   <= ptr_d;
`ifdef SA9_SCHED_WATCHDOG_EN
               end else if (expire) begin
                  state_q  <= IDLE;
                  grant_q  <= '0;
                  busy_q   <= 1'b0;
                  ptr_q    <= ptr_d;
                  tpulse_q <= 1'b1;
                  tid_q    <= gid_q;
               end else begin
                  tmr_q <= tmr_q + 1'b1;
`endif
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign sched_if.grant    = grant_q;
   assign sched_if.grant_id = gid_q;
   assign sched_if.busy     = busy_q;

`ifdef SA9_SCHED_WATCHDOG_EN
   assign sched_if.timeout_pulse = tpulse_q;
   assign sched_if.timeout_id    = tid_q;
`else
   assign sched_if.timeout_pulse = 1'b0;
   assign sched_if.timeout_id    = '0;
`endif

endmodule

// File: doc/sa9_grant_scheduler.md
# sa9_grant_scheduler

Round-robin scheduler that shares one resource among the five leaf instances (inst_0..inst_4) of an sa8-level hierarchy node. Each leaf raises a request, receives an exclusive one-hot grant, and returns a done strobe. A watchdog can optionally reclaim the resource from a hung leaf. The block sits in the sa8-level parent, between the leaf instances and the shared resource.

## Interface
- NUM_REQ, 5, number of requesting leaf instances (2..16)
- ID_W, $clog2(NUM_REQ), width of grant/timeout index
- TIMEOUT_CYC, 200, max cycles a grant may be held (watchdog build only; ≥2)
- TMR_W, 8, watchdog counter width; must satisfy 2^TMR_W > TIMEOUT_CYC

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  level request per leaf
- done  in  NUM_REQ  one-cycle completion strobe per leaf
- grant  out  NUM_REQ  one-hot (or zero) grant, registered
- grant_id  out  ID_W  index of granted leaf; valid while busy
- busy  out  1  a grant is active
- timeout_pulse  out  1  one-cycle strobe on watchdog reclaim
- timeout_id  out  ID_W  leaf reclaimed; held until next timeout

## Operation
- FSM: IDLE, GRANT.
- IDLE: if any req bit set, pick the first set bit at or after pointer `ptr`, scanning upward with wrap-around modulo NUM_REQ; register grant, grant_id, busy=1; go GRANT. No request: stay IDLE, outputs low.
- GRANT: hold grant unchanged. done[grant_id]=1 → clear grant/busy, `ptr` = (grant_id+1) mod NUM_REQ, go IDLE.
- done bits of non-granted leaves are ignored in all states.
- Dropping req while granted does not release the grant; only done (or watchdog) releases.
- Watchdog (macro enabled): counter clears on entry to GRANT, increments every GRANT cycle. When counter = TIMEOUT_CYC-1 and no done that cycle: release as for done, advance `ptr` past the hung leaf, pulse timeout_pulse, load timeout_id. done and expiry in the same cycle: treat as normal done, no timeout pulse.
- Reset values: state IDLE, ptr 0, grant 0, grant_id 0, busy 0, timeout_pulse 0, timeout_id 0, counter 0.
- Reset asserted mid-grant: all outputs drop asynchronously; after release, arbitration restarts from leaf 0.

## Timing
- Request-to-grant: req sampled in IDLE at edge N → grant high after edge N.
- done sampled at edge M → grant low after edge M; earliest next grant after edge M+1. Grant is low for exactly one cycle between back-to-back grants.
- done in the first grant cycle is accepted: minimum grant length 1 cycle.
- Watchdog: grant high for exactly TIMEOUT_CYC cycles, then released; timeout_pulse coincides with the first grant-low cycle.
- No combinational paths from inputs to outputs.

## Configuration
- SA9_SCHED_WATCHDOG_EN defined: watchdog counter and timeout outputs implemented as above.
- Not defined: no counter; a grant is held until done indefinitely; timeout_pulse and timeout_id are tied to 0.

## Test plan
- Reset, then req=5'b00100 → grant=5'b00100 and grant_id=2 one cycle later. done[2] pulse → grant=0 next cycle, ptr=3.
- req=5'b11111 held, each leaf returns done after 3 grant cycles → grant order 0,1,2,3,4,0; each grant lasts 3 cycles, with a 1-cycle gap between grants.
- Leaf 1 granted, done[3] pulsed → ignored and grant unchanged. req[1] dropped → grant held until done[1].
- Wrap: ptr=4, req=5'b00011 → leaf 0 granted. Then done[0] with req=5'b00011 → leaf 1 granted.
- Watchdog (macro on, TIMEOUT_CYC=200): leaf 2 granted, never done → grant low after 200 cycles, timeout_pulse=1 for 1 cycle, timeout_id=2, next grant goes to the next requester ≥3. Macro off: grant is still held at cycle 1000.
- rst_n driven low mid-grant for 1 cycle → grant/busy drop immediately. After release with req=5'b10001 → leaf 0 granted.
